// File: rtl/mips_stack_pkg.sv
// Shared definitions for the stack-MIPS operand stack.
// Provides the default stack geometry and the push/pop action encoding
// that the controller and the stack decode agree on.
package mips_stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;

  // Encoded as {push, pop}; replace is push and pop in the same cycle.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array backing the operand stack.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  asynchronous read address
//   rdata  asynchronous read data
// Contents are deliberately not reset.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_lifo.sv
// Operand stack (LIFO) for the multi-cycle stack-MIPS datapath.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   push       write din onto the stack
//   pop        remove the top entry
//   din        data to push or replace the top with
//   dout       top of stack, 0 when empty
//   count      number of valid entries
//   empty      count == 0
//   full       count == DEPTH
//   overflow   registered pulse: a push was refused because full
//   underflow  registered pulse: a pop was refused because empty
// dout/empty/full depend only on registered state.
module stack_lifo
  import mips_stack_pkg::*;
#(
  parameter int  WIDTH = STACK_WIDTH,
  parameter int  DEPTH = STACK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    unique case (decode_op(push, pop))
      OP_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = AW'(count_q);
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (is_empty) udf_d = 1'b1;
        else          count_d = count_q - CNT_W'(1);
      end
      OP_REPL: begin
        // On an empty stack a replace degrades to a plain push.
        we = 1'b1;
        if (is_empty) begin
          waddr   = '0;
          count_d = CNT_W'(1);
        end else begin
          waddr = AW'(count_q - CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Hold the read address in range while empty; dout is forced to 0 anyway.
  assign raddr = is_empty ? '0 : AW'(count_q - CNT_W'(1));

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign dout      = is_empty ? '0 : rdata;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
